// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage constants, context struct and bubble helper
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0;
  localparam logic [4:0]  REG_ZERO   = 5'd0;

  // Widest PC any stage register carries; narrower ADDR_W values zero-extend into it.
  localparam int unsigned CTX_ADDR_W = 32;

  typedef struct packed {
    logic [31:0]           instr;
    logic [CTX_ADDR_W-1:0] pc;
    logic [CTX_ADDR_W-1:0] pc8;
    logic [4:0]            a3;
    logic                  valid;
  } stage_ctx_t;

  // A bubble is a nop with no destination; the PCs are supplied by the caller so a
  // flushed slot can still report where the squashed instruction came from.
  function automatic stage_ctx_t bubble_ctx(input logic [CTX_ADDR_W-1:0] pc,
                                            input logic [CTX_ADDR_W-1:0] pc8);
    stage_ctx_t c;
    c.instr = NOP_INSTR;
    c.pc    = pc;
    c.pc8   = pc8;
    c.a3    = REG_ZERO;
    c.valid = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - CNT_W-wide saturating up-counter with enable
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  assign o_count  = r_count;

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall, flush bubble and optional stall counter (PIPE_STAGE_PERF_EN)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W        = 64,
  parameter int ADDR_W           = 32,
  parameter int KEEP_PC_ON_FLUSH = 1,
  parameter int CNT_W            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [31:0]          instr_in,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic [ADDR_W-1:0]    pc8_in,
  input  logic [4:0]           a3_in,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [31:0]          instr_out,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [ADDR_W-1:0]    pc8_out,
  output logic [4:0]           a3_out,
  output logic [PAYLOAD_W-1:0] payload_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  // Reject configurations the context struct or counter cannot represent.
  if (ADDR_W < 1 || ADDR_W > CTX_ADDR_W || PAYLOAD_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipe_stage_reg: unsupported parameter combination");
  end

  stage_ctx_t             r_ctx;
  logic [PAYLOAD_W-1:0]   r_payload;
  stage_ctx_t             w_next_ctx;
  logic [PAYLOAD_W-1:0]   w_next_payload;
  logic [CTX_ADDR_W-1:0]  w_pc_ext;
  logic [CTX_ADDR_W-1:0]  w_pc8_ext;

  assign w_pc_ext  = CTX_ADDR_W'(pc_in);
  assign w_pc8_ext = CTX_ADDR_W'(pc8_in);

  // Next slot contents: flush beats stall beats load; an invalid load never carries a
  // destination or instruction so nothing downstream forwards from or writes back a bubble.
  always_comb begin
    w_next_ctx     = r_ctx;
    w_next_payload = r_payload;
    if (flush) begin
      if (KEEP_PC_ON_FLUSH != 0) begin
        w_next_ctx = bubble_ctx(w_pc_ext, w_pc8_ext);
      end else begin
        w_next_ctx = bubble_ctx('0, '0);
      end
      w_next_payload = '0;
    end else if (!stall) begin
      w_next_ctx.valid = valid_in;
      w_next_ctx.instr = valid_in ? instr_in : NOP_INSTR;
      w_next_ctx.a3    = valid_in ? a3_in : REG_ZERO;
      w_next_ctx.pc    = w_pc_ext;
      w_next_ctx.pc8   = w_pc8_ext;
      w_next_payload   = payload_in;
    end
  end

  // Slot register; reset wins over every other control on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctx     <= '0;
      r_payload <= '0;
    end else begin
      r_ctx     <= w_next_ctx;
      r_payload <= w_next_payload;
    end
  end

  assign valid_out   = r_ctx.valid;
  assign instr_out   = r_ctx.instr;
  assign pc_out      = r_ctx.pc[ADDR_W-1:0];
  assign pc8_out     = r_ctx.pc8[ADDR_W-1:0];
  assign a3_out      = r_ctx.a3;
  assign payload_out = r_payload;

`ifdef PIPE_STAGE_PERF_EN
  logic w_cnt_en;

  // Only a real instruction held by stall counts; a flush in the same cycle does not.
  assign w_cnt_en = stall && !flush && r_ctx.valid;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk    (clk),
    .i_resetn (reset),
    .i_en     (w_cnt_en),
    .o_count  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (PC-keeping and PC-zeroing instances)
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in;
  logic [31:0] instr_in, pc_in, pc8_in;
  logic [4:0]  a3_in;
  logic [63:0] payload_in;

  logic        k_valid, z_valid;
  logic [31:0] k_instr, z_instr, k_pc, z_pc, k_pc8, z_pc8;
  logic [4:0]  k_a3, z_a3;
  logic [63:0] k_payload, z_payload;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] k_cnt;
  logic [1:0]  z_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: what the slot should hold, expressed as "instruction or bubble".
  bit          m_valid;
  logic [31:0] m_instr, m_pc_k, m_pc8_k, m_pc_z, m_pc8_z;
  logic [4:0]  m_a3;
  logic [63:0] m_payload;
  int          m_cnt_k, m_cnt_z;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(64), .ADDR_W(32), .KEEP_PC_ON_FLUSH(1), .CNT_W(16)) dut_k (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc_in(pc_in), .pc8_in(pc8_in), .a3_in(a3_in), .payload_in(payload_in),
    .valid_out(k_valid), .instr_out(k_instr), .pc_out(k_pc), .pc8_out(k_pc8),
    .a3_out(k_a3), .payload_out(k_payload)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(k_cnt)
`endif
  );

  pipe_stage_reg #(.PAYLOAD_W(64), .ADDR_W(32), .KEEP_PC_ON_FLUSH(0), .CNT_W(2)) dut_z (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc_in(pc_in), .pc8_in(pc8_in), .a3_in(a3_in), .payload_in(payload_in),
    .valid_out(z_valid), .instr_out(z_instr), .pc_out(z_pc), .pc8_out(z_pc8),
    .a3_out(z_a3), .payload_out(z_payload)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(z_cnt)
`endif
  );

  task automatic model_step();
    if (!reset) begin
      m_valid = 0; m_instr = 0; m_a3 = 0; m_payload = 0;
      m_pc_k = 0; m_pc8_k = 0; m_pc_z = 0; m_pc8_z = 0;
      m_cnt_k = 0; m_cnt_z = 0;
    end else if (flush) begin
      m_valid = 0; m_instr = 0; m_a3 = 0; m_payload = 0;
      m_pc_k = pc_in; m_pc8_k = pc8_in; m_pc_z = 0; m_pc8_z = 0;
    end else if (stall) begin
      if (m_valid) begin
        m_cnt_k = (m_cnt_k + 1 > 65535) ? 65535 : m_cnt_k + 1;
        m_cnt_z = (m_cnt_z + 1 > 3) ? 3 : m_cnt_z + 1;
      end
    end else begin
      m_valid   = valid_in;
      m_instr   = valid_in ? instr_in : 32'h0;
      m_a3      = valid_in ? a3_in : 5'd0;
      m_payload = payload_in;
      m_pc_k = pc_in; m_pc8_k = pc8_in; m_pc_z = pc_in; m_pc8_z = pc8_in;
    end
  endtask

  // One clock: model advances on the edge, outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_data();
    instr_in   = $urandom;
    pc_in      = $urandom & 32'hFFFF_FFFC;
    pc8_in     = pc_in + 32'd8;
    a3_in      = 5'($urandom);
    payload_in = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rand_data(); reset = 0; stall = 1; flush = 0; valid_in = 1;
    tick();
    n_total++;
    if ({k_valid, k_instr, k_pc, k_pc8, k_a3, k_payload} !== '0)
      begin n_bad++; $display("FAIL reset_k: got %h required 0", {k_valid, k_instr, k_pc, k_pc8, k_a3, k_payload}); end
    n_total++;
    if ({z_valid, z_instr, z_pc, z_pc8, z_a3, z_payload} !== '0)
      begin n_bad++; $display("FAIL reset_z: got %h required 0", {z_valid, z_instr, z_pc, z_pc8, z_a3, z_payload}); end
`ifdef PIPE_STAGE_PERF_EN
    n_total++;
    if (k_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d required 0", k_cnt); end
`endif
    reset = 1; stall = 0; valid_in = 1;
    instr_in = 32'h8C220004; pc_in = 32'h00003000; pc8_in = 32'h00003008; a3_in = 5'd2;
    tick();
    n_total++;
    if (k_instr !== 32'h8C220004 || k_pc !== 32'h00003000 || k_pc8 !== 32'h00003008 || k_valid !== 1'b1)
      begin n_bad++; $display("FAIL first_load: got instr=%h pc=%h pc8=%h v=%b required 8c220004 00003000 00003008 1", k_instr, k_pc, k_pc8, k_valid); end
  endtask

  task automatic test_stall();
    rand_data(); a3_in = 5'd3; valid_in = 1; stall = 0; flush = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1; rand_data();
      tick();
      n_total++;
      if (k_a3 !== 5'd3 || k_instr !== m_instr || z_pc !== m_pc_z || k_payload !== m_payload)
        begin n_bad++; $display("FAIL stall_hold[%0d]: got a3=%0d instr=%h required a3=3 instr=%h", i, k_a3, k_instr, m_instr); end
    end
`ifdef PIPE_STAGE_PERF_EN
    n_total++;
    if (k_cnt !== 16'd3 || z_cnt !== 2'd3)
      begin n_bad++; $display("FAIL stall_cnt: got k=%0d z=%0d required 3 3", k_cnt, z_cnt); end
`endif
    stall = 0; rand_data(); a3_in = 5'd9;
    tick();
    n_total++;
    if (k_a3 !== 5'd9 || k_pc !== pc_in)
      begin n_bad++; $display("FAIL stall_resume: got a3=%0d pc=%h required 9 %h", k_a3, k_pc, pc_in); end
  endtask

  task automatic test_flush();
    rand_data(); flush = 1; stall = 0; valid_in = 1;
    pc_in = 32'h00003010; pc8_in = 32'h00003018;
    tick();
    n_total++;
    if (k_valid !== 1'b0 || k_instr !== 32'h0 || k_a3 !== 5'd0 || k_payload !== 64'h0 || k_pc !== 32'h00003010 || k_pc8 !== 32'h00003018)
      begin n_bad++; $display("FAIL flush_keep: got v=%b instr=%h a3=%0d pc=%h pc8=%h required 0 0 0 00003010 00003018", k_valid, k_instr, k_a3, k_pc, k_pc8); end
    n_total++;
    if (z_valid !== 1'b0 || z_pc !== 32'h0 || z_pc8 !== 32'h0)
      begin n_bad++; $display("FAIL flush_zero: got v=%b pc=%h pc8=%h required 0 0 0", z_valid, z_pc, z_pc8); end
    flush = 0;
  endtask

  task automatic test_stall_flush();
    int pk, pz;
    rand_data(); valid_in = 1; stall = 0; flush = 0;
    tick();
    pk = m_cnt_k; pz = m_cnt_z;
    rand_data(); stall = 1; flush = 1;
    tick();
    n_total++;
    if (k_valid !== 1'b0 || k_a3 !== 5'd0 || k_instr !== 32'h0 || k_pc !== pc_in)
      begin n_bad++; $display("FAIL stall_flush: got v=%b a3=%0d pc=%h required 0 0 %h", k_valid, k_a3, k_pc, pc_in); end
`ifdef PIPE_STAGE_PERF_EN
    n_total++;
    if (k_cnt !== 16'(pk) || z_cnt !== 2'(pz))
      begin n_bad++; $display("FAIL stall_flush_cnt: got k=%0d z=%0d required %0d %0d", k_cnt, z_cnt, pk, pz); end
`endif
    stall = 0; flush = 0;
  endtask

  task automatic test_invalid_load();
    rand_data(); instr_in = 32'hDEADBEEF; valid_in = 0; a3_in = 5'd7; stall = 0; flush = 0;
    tick();
    n_total++;
    if (k_a3 !== 5'd0 || k_instr !== 32'h0 || k_valid !== 1'b0 || k_payload !== payload_in || z_pc !== pc_in)
      begin n_bad++; $display("FAIL invalid_load: got a3=%0d instr=%h v=%b required 0 0 0", k_a3, k_instr, k_valid); end
  endtask

  task automatic test_saturation();
    reset = 0; stall = 0; flush = 0; tick();
    reset = 1; rand_data(); valid_in = 1; tick();
    for (int i = 0; i < 6; i++) begin
      stall = 1; rand_data(); tick();
    end
`ifdef PIPE_STAGE_PERF_EN
    n_total++;
    if (z_cnt !== 2'd3 || k_cnt !== 16'd6)
      begin n_bad++; $display("FAIL saturate: got z=%0d k=%0d required 3 6", z_cnt, k_cnt); end
`endif
    reset = 0; stall = 1; tick();
    n_total++;
    if (k_valid !== 1'b0 || k_payload !== 64'h0 || z_instr !== 32'h0)
      begin n_bad++; $display("FAIL reset_mid_stall: got v=%b payload=%h required 0 0", k_valid, k_payload); end
`ifdef PIPE_STAGE_PERF_EN
    n_total++;
    if (z_cnt !== 2'd0 || k_cnt !== 16'd0)
      begin n_bad++; $display("FAIL reset_mid_stall_cnt: got z=%0d k=%0d required 0 0", z_cnt, k_cnt); end
`endif
    reset = 1; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_data();
      reset    = ($urandom_range(0, 99) >= 3);
      stall    = ($urandom_range(0, 99) < 30);
      flush    = ($urandom_range(0, 99) < 12);
      valid_in = ($urandom_range(0, 99) < 75);
      tick();
      n_total++;
      if ({k_valid, k_instr, k_pc, k_pc8, k_a3, k_payload} !== {m_valid, m_instr, m_pc_k, m_pc8_k, m_a3, m_payload})
        begin n_bad++; $display("FAIL rand_k[%0d]: got %h required %h", i, {k_valid, k_instr, k_pc, k_pc8, k_a3, k_payload}, {m_valid, m_instr, m_pc_k, m_pc8_k, m_a3, m_payload}); end
      n_total++;
      if ({z_valid, z_instr, z_pc, z_pc8, z_a3, z_payload} !== {m_valid, m_instr, m_pc_z, m_pc8_z, m_a3, m_payload})
        begin n_bad++; $display("FAIL rand_z[%0d]: got %h required %h", i, {z_valid, z_instr, z_pc, z_pc8, z_a3, z_payload}, {m_valid, m_instr, m_pc_z, m_pc8_z, m_a3, m_payload}); end
      if (k_valid === 1'b0) begin
        n_total++;
        if (k_a3 !== 5'd0 || k_instr !== 32'h0)
          begin n_bad++; $display("FAIL invariant[%0d]: got a3=%0d instr=%h required 0 0", i, k_a3, k_instr); end
      end
`ifdef PIPE_STAGE_PERF_EN
      n_total++;
      if (k_cnt !== 16'(m_cnt_k) || z_cnt !== 2'(m_cnt_z))
        begin n_bad++; $display("FAIL rand_cnt[%0d]: got k=%0d z=%0d required %0d %0d", i, k_cnt, z_cnt, m_cnt_k, m_cnt_z); end
`endif
    end
  endtask

  initial begin
    reset = 0; stall = 0; flush = 0; valid_in = 0;
    instr_in = 0; pc_in = 0; pc8_in = 0; a3_in = 0; payload_in = 0;
    m_valid = 0; m_instr = 0; m_a3 = 0; m_payload = 0;
    m_pc_k = 0; m_pc8_k = 0; m_pc_z = 0; m_pc8_z = 0; m_cnt_k = 0; m_cnt_z = 0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_flush();
    test_stall_flush();
    test_invalid_load();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
